// File: rtl/tick_scheduler.sv
// Multi-channel clock-enable scheduler: per-channel one-cycle ticks at programmable divisors,
// with shadowed divisor updates applied at period boundaries. Optional macro: TICK_SCHED_SYNC_EN.
module tick_scheduler #(
    parameter int N_CH    = 3,
    parameter int DIV_W   = 16,
    parameter int DEF_DIV = 2,
    localparam int CH_W   = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cfg_valid,
    output logic              cfg_ready,
    input  logic [CH_W-1:0]   cfg_ch,
    input  logic [DIV_W-1:0]  cfg_div,
    input  logic [N_CH-1:0]   ch_en,
    input  logic              pause,
    output logic [N_CH-1:0]   tick,
    output logic [N_CH-1:0]   pending
`ifdef TICK_SCHED_SYNC_EN
    ,
    input  logic              sync
`endif
);

    typedef enum logic [1:0] {
        CH_OFF      = 2'd0,
        CH_RUN      = 2'd1,
        CH_RUN_PEND = 2'd2
    } ch_state_e;

    localparam logic [DIV_W-1:0] ONE_DIV = DIV_W'(1);
    localparam logic [DIV_W-1:0] DEF_VAL = DIV_W'(DEF_DIV);

    logic [DIV_W-1:0] cnt_q     [N_CH];
    logic [DIV_W-1:0] cnt_d     [N_CH];
    logic [DIV_W-1:0] div_act_q [N_CH];
    logic [DIV_W-1:0] div_act_d [N_CH];
    logic [DIV_W-1:0] div_shd_q [N_CH];
    logic [DIV_W-1:0] div_shd_d [N_CH];
    logic [N_CH-1:0]  pend_q;
    logic [N_CH-1:0]  pend_d;
    logic [N_CH-1:0]  tick_q;
    logic [N_CH-1:0]  tick_d;

    logic [N_CH-1:0]  sel_s;
    logic             accept_s;
    logic             sync_s;
    logic [DIV_W-1:0] cfg_div_s;
    ch_state_e        ch_state_s [N_CH];

`ifdef TICK_SCHED_SYNC_EN
    assign sync_s = sync;
`else
    assign sync_s = 1'b0;
`endif

    // Channel select, handshake and per-channel state decode.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            sel_s[i] = (cfg_ch == CH_W'(i));
            if (!ch_en[i]) begin
                ch_state_s[i] = CH_OFF;
            end else if (pend_q[i]) begin
                ch_state_s[i] = CH_RUN_PEND;
            end else begin
                ch_state_s[i] = CH_RUN;
            end
        end
        // An out-of-range channel matches no select bit, so it is always ready.
        cfg_ready = ~|(sel_s & pend_q);
        accept_s  = cfg_valid && cfg_ready;
        cfg_div_s = (cfg_div == {DIV_W{1'b0}}) ? ONE_DIV : cfg_div;
    end

    // Next-state logic for counters, divisors, pending flags and ticks.
    always_comb begin
        for (int i = 0; i < N_CH; i++) begin
            cnt_d[i]     = cnt_q[i];
            div_act_d[i] = div_act_q[i];
            div_shd_d[i] = div_shd_q[i];
            pend_d[i]    = pend_q[i];
            tick_d[i]    = 1'b0;

            if (sync_s) begin
                cnt_d[i] = {DIV_W{1'b0}};
                if (pend_q[i]) begin
                    div_act_d[i] = div_shd_q[i];
                    pend_d[i]    = 1'b0;
                end else begin
                    div_act_d[i] = div_act_q[i];
                end
            end else if (pause) begin
                tick_d[i] = 1'b0;
            end else begin
                case (ch_state_s[i])
                    CH_OFF: begin
                        // A disabled channel has no period to protect, so apply at once.
                        cnt_d[i] = {DIV_W{1'b0}};
                        if (pend_q[i]) begin
                            div_act_d[i] = div_shd_q[i];
                            pend_d[i]    = 1'b0;
                        end else begin
                            div_act_d[i] = div_act_q[i];
                        end
                    end
                    CH_RUN: begin
                        if (cnt_q[i] == div_act_q[i] - ONE_DIV) begin
                            cnt_d[i]  = {DIV_W{1'b0}};
                            tick_d[i] = 1'b1;
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE_DIV;
                        end
                    end
                    CH_RUN_PEND: begin
                        if (cnt_q[i] == div_act_q[i] - ONE_DIV) begin
                            cnt_d[i]     = {DIV_W{1'b0}};
                            tick_d[i]    = 1'b1;
                            div_act_d[i] = div_shd_q[i];
                            pend_d[i]    = 1'b0;
                        end else begin
                            cnt_d[i] = cnt_q[i] + ONE_DIV;
                        end
                    end
                    default: begin
                        cnt_d[i] = {DIV_W{1'b0}};
                    end
                endcase
            end

            // Only a non-pending channel can accept, so this never overwrites a queued divisor.
            if (accept_s && sel_s[i]) begin
                div_shd_d[i] = cfg_div_s;
                pend_d[i]    = 1'b1;
            end else begin
                div_shd_d[i] = div_shd_q[i];
            end
        end
    end

    // State registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]     <= {DIV_W{1'b0}};
                div_act_q[i] <= DEF_VAL;
                div_shd_q[i] <= DEF_VAL;
            end
            pend_q <= {N_CH{1'b0}};
            tick_q <= {N_CH{1'b0}};
        end else begin
            for (int i = 0; i < N_CH; i++) begin
                cnt_q[i]     <= cnt_d[i];
                div_act_q[i] <= div_act_d[i];
                div_shd_q[i] <= div_shd_d[i];
            end
            pend_q <= pend_d;
            tick_q <= tick_d;
        end
    end

    assign tick    = tick_q;
    assign pending = pend_q;

endmodule

// File: tb/tb_tick_scheduler.sv
// Directed testbench for tick_scheduler; edge numbers count rising edges after reset release.
module tb_tick_scheduler;

    logic        clk;
    logic        rst;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [1:0]  cfg_ch;
    logic [15:0] cfg_div;
    logic [2:0]  ch_en;
    logic        pause;
    logic [2:0]  tick;
    logic [2:0]  pending;
`ifdef TICK_SCHED_SYNC_EN
    logic        sync;
`endif

    int pass_cnt;
    int total_cnt;
    int edge_no;

    tick_scheduler #(.N_CH(3), .DIV_W(16), .DEF_DIV(2)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_ch    (cfg_ch),
        .cfg_div   (cfg_div),
        .ch_en     (ch_en),
        .pause     (pause),
        .tick      (tick),
        .pending   (pending)
`ifdef TICK_SCHED_SYNC_EN
        ,
        .sync      (sync)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
        edge_no++;
    endtask

    task automatic test_reset();
        repeat (3) @(posedge clk);
        #1;
        total_cnt++;
        if (tick !== 3'b000) $display("FAIL reset_tick: got %b expected %b", tick, 3'b000);
        else pass_cnt++;
        total_cnt++;
        if (pending !== 3'b000) $display("FAIL reset_pending: got %b expected %b", pending, 3'b000);
        else pass_cnt++;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL reset_ready: got %b expected %b", cfg_ready, 1'b1);
        else pass_cnt++;
        rst = 1'b0;
        ch_en = 3'b111;
        edge_no = 0;
    endtask

    task automatic test_default_rate();
        logic [2:0] exp;
        for (int k = 1; k <= 6; k++) begin
            step();
            exp = (edge_no % 2 == 0) ? 3'b111 : 3'b000;
            total_cnt++;
            if (tick !== exp) $display("FAIL default_tick e%0d: got %b expected %b", edge_no, tick, exp);
            else pass_cnt++;
        end
        total_cnt++;
        if (pending !== 3'b000) $display("FAIL default_pending: got %b expected %b", pending, 3'b000);
        else pass_cnt++;
    endtask

    task automatic test_cfg_div5();
        logic [2:0] exp;
        cfg_valid = 1'b1; cfg_ch = 2'd1; cfg_div = 16'd5;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL cfg5_ready_before: got %b expected %b", cfg_ready, 1'b1);
        else pass_cnt++;
        step();  // edge 7: accepted
        cfg_valid = 1'b0;
        total_cnt++;
        if (pending !== 3'b010 || tick !== 3'b000)
            $display("FAIL cfg5_accept: got pending %b tick %b expected 010 000", pending, tick);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL cfg5_ready_ch1: got %b expected %b", cfg_ready, 1'b0);
        else pass_cnt++;
        cfg_ch = 2'd0;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL cfg5_ready_ch0: got %b expected %b", cfg_ready, 1'b1);
        else pass_cnt++;
        step();  // edge 8: ch1 wraps on old divisor and loads 5
        total_cnt++;
        if (tick !== 3'b111 || pending !== 3'b000)
            $display("FAIL cfg5_boundary: got tick %b pending %b expected 111 000", tick, pending);
        else pass_cnt++;
        for (int k = 0; k < 10; k++) begin
            step();
            exp = {edge_no % 2 == 0, (edge_no - 8) % 5 == 0, edge_no % 2 == 0};
            total_cnt++;
            if (tick !== exp) $display("FAIL cfg5_tick e%0d: got %b expected %b", edge_no, tick, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_div_zero_and_drop();
        logic [2:0] exp;
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd0;
        step();  // edge 19
        cfg_valid = 1'b0;
        total_cnt++;
        if (pending !== 3'b100 || tick !== 3'b000)
            $display("FAIL div0_accept: got pending %b tick %b expected 100 000", pending, tick);
        else pass_cnt++;
        step();  // edge 20
        total_cnt++;
        if (tick !== 3'b101 || pending !== 3'b000)
            $display("FAIL div0_boundary: got tick %b pending %b expected 101 000", tick, pending);
        else pass_cnt++;
        for (int k = 0; k < 3; k++) begin
            step();
            exp = {1'b1, edge_no == 23, edge_no % 2 == 0};
            total_cnt++;
            if (tick !== exp) $display("FAIL div0_tick e%0d: got %b expected %b", edge_no, tick, exp);
            else pass_cnt++;
        end
        cfg_valid = 1'b1; cfg_ch = 2'd3; cfg_div = 16'd7;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b1) $display("FAIL drop_ready: got %b expected %b", cfg_ready, 1'b1);
        else pass_cnt++;
        step();  // edge 24
        cfg_valid = 1'b0;
        total_cnt++;
        if (pending !== 3'b000 || tick !== 3'b101)
            $display("FAIL drop_state: got pending %b tick %b expected 000 101", pending, tick);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step();
            exp = {1'b1, edge_no == 28, edge_no % 2 == 0};
            total_cnt++;
            if (tick !== exp) $display("FAIL drop_tick e%0d: got %b expected %b", edge_no, tick, exp);
            else pass_cnt++;
        end
    endtask

    task automatic test_pause();
        logic [2:0] exp_after [4];
        exp_after = '{3'b101, 3'b100, 3'b101, 3'b110};
        step();  // edge 29: ch0 cnt=1
        total_cnt++;
        if (tick !== 3'b100) $display("FAIL pause_pre: got %b expected %b", tick, 3'b100);
        else pass_cnt++;
        pause = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            total_cnt++;
            if (tick !== 3'b000) $display("FAIL pause_hold e%0d: got %b expected %b", edge_no, tick, 3'b000);
            else pass_cnt++;
        end
        pause = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++;
            if (tick !== exp_after[k])
                $display("FAIL pause_resume e%0d: got %b expected %b", edge_no, tick, exp_after[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_disable_reenable();
        logic [2:0] exp_en [4];
        exp_en = '{3'b001, 3'b000, 3'b011, 3'b100};
        cfg_valid = 1'b1; cfg_ch = 2'd2; cfg_div = 16'd4;
        step();  // edge 37
        cfg_valid = 1'b0;
        ch_en = 3'b011;
        total_cnt++;
        if (tick !== 3'b101 || pending !== 3'b100)
            $display("FAIL dis_accept: got tick %b pending %b expected 101 100", tick, pending);
        else pass_cnt++;
        step();  // edge 38: channel off, divisor applied immediately
        total_cnt++;
        if (pending !== 3'b000 || tick !== 3'b000)
            $display("FAIL dis_clear: got pending %b tick %b expected 000 000", pending, tick);
        else pass_cnt++;
        ch_en = 3'b111;
        for (int k = 0; k < 4; k++) begin
            step();
            total_cnt++;
            if (tick !== exp_en[k])
                $display("FAIL reen_tick e%0d: got %b expected %b", edge_no, tick, exp_en[k]);
            else pass_cnt++;
        end
    endtask

    task automatic test_back_to_back_wrap();
        logic exp_t0 [5];
        exp_t0 = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b1};
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd3;
        step();  // edge 43: accept coincides with ch0 wrap
        cfg_valid = 1'b0;
        total_cnt++;
        if (tick[0] !== 1'b1 || pending[0] !== 1'b1)
            $display("FAIL wrap_accept: got tick0 %b pend0 %b expected 1 1", tick[0], pending[0]);
        else pass_cnt++;
        #1;
        total_cnt++;
        if (cfg_ready !== 1'b0) $display("FAIL wrap_ready: got %b expected %b", cfg_ready, 1'b0);
        else pass_cnt++;
        for (int k = 0; k < 5; k++) begin
            step();
            total_cnt++;
            if (tick[0] !== exp_t0[k])
                $display("FAIL wrap_tick0 e%0d: got %b expected %b", edge_no, tick[0], exp_t0[k]);
            else pass_cnt++;
            if (edge_no == 45) begin
                total_cnt++;
                if (pending !== 3'b000) $display("FAIL wrap_pending: got %b expected %b", pending, 3'b000);
                else pass_cnt++;
            end
        end
    endtask

`ifdef TICK_SCHED_SYNC_EN
    task automatic test_sync();
        logic [2:0] exp;
        cfg_valid = 1'b1; cfg_ch = 2'd0; cfg_div = 16'd4;
        step();  // edge 49
        cfg_ch = 2'd1;
        step();  // edge 50
        cfg_valid = 1'b0;
        total_cnt++;
        if (pending !== 3'b011) $display("FAIL sync_pend: got %b expected %b", pending, 3'b011);
        else pass_cnt++;
        sync = 1'b1;
        step();  // edge 51
        sync = 1'b0;
        total_cnt++;
        if (tick !== 3'b000 || pending !== 3'b000)
            $display("FAIL sync_pulse: got tick %b pending %b expected 000 000", tick, pending);
        else pass_cnt++;
        for (int k = 0; k < 4; k++) begin
            step();
            exp = (edge_no == 55) ? 3'b111 : 3'b000;
            total_cnt++;
            if (tick !== exp) $display("FAIL sync_tick e%0d: got %b expected %b", edge_no, tick, exp);
            else pass_cnt++;
        end
    endtask
`endif

    initial begin
        pass_cnt = 0;
        total_cnt = 0;
        edge_no = 0;
        rst = 1'b1;
        cfg_valid = 1'b0;
        cfg_ch = 2'd0;
        cfg_div = 16'd0;
        ch_en = 3'b000;
        pause = 1'b0;
`ifdef TICK_SCHED_SYNC_EN
        sync = 1'b0;
`endif
        test_reset();
        test_default_rate();
        test_cfg_div5();
        test_div_zero_and_drop();
        test_pause();
        test_disable_reenable();
        test_back_to_back_wrap();
`ifdef TICK_SCHED_SYNC_EN
        test_sync();
`endif
        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
